// File: rtl/sc_speedtimer.sv
// Shift-period timer: counts upcount strobes and drives T0_OutLow low once the level-dependent limit is reached.
// Optional level progression under SC_SPEEDTIMER_LEVELUP_EN; T0 decodes straight from registers, zero latency.
module sc_speedtimer #(
    parameter int                      COUNT_WIDTH      = 24,
    parameter logic [COUNT_WIDTH-1:0]  BASE_LIMIT       = 24'd200000,
    parameter logic [COUNT_WIDTH-1:0]  LEVEL_STEP       = 24'd20000,
    parameter logic [COUNT_WIDTH-1:0]  MIN_LIMIT        = 24'd40000,
    parameter int                      LEVEL_WIDTH      = 3,
    parameter int                      SHIFTS_PER_LEVEL = 16
) (
    input  logic                   SC_SPEEDTIMER_CLOCK_50,
    input  logic                   SC_SPEEDTIMER_RESET_InLow,
    input  logic                   SC_SPEEDTIMER_clear_InLow,
    input  logic                   SC_SPEEDTIMER_load_InLow,
    input  logic                   SC_SPEEDTIMER_upcount_InLow,
    output logic                   SC_SPEEDTIMER_T0_OutLow,
    output logic [LEVEL_WIDTH-1:0] SC_SPEEDTIMER_level_Out,
    output logic                   SC_SPEEDTIMER_levelUp_OutHigh
);

    localparam int LW = COUNT_WIDTH + LEVEL_WIDTH;

    generate
        if (SHIFTS_PER_LEVEL < 1 || MIN_LIMIT == '0 || MIN_LIMIT > BASE_LIMIT) begin : g_bad_params
            $error("sc_speedtimer: invalid limit or shift parameters");
        end
    endgenerate

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [LEVEL_WIDTH-1:0] level_w;
    logic                   level_up_w;
    logic [LW-1:0]          product;
    logic [COUNT_WIDTH-1:0] limit;

`ifdef SC_SPEEDTIMER_LEVELUP_EN
    localparam int SHIFT_W = (SHIFTS_PER_LEVEL > 1) ? $clog2(SHIFTS_PER_LEVEL) : 1;

    logic [SHIFT_W-1:0]     shifts_q, shifts_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   level_up_q, level_up_d;

    assign level_w    = level_q;
    assign level_up_w = level_up_q;
`else
    assign level_w    = '0;
    assign level_up_w = 1'b0;
`endif

    // With progression disabled level_w is zero, so this folds to BASE_LIMIT.
    always_comb begin
        product = {{COUNT_WIDTH{1'b0}}, level_w} * {{LEVEL_WIDTH{1'b0}}, LEVEL_STEP};
        if (product >= {{LEVEL_WIDTH{1'b0}}, BASE_LIMIT - MIN_LIMIT}) begin
            limit = MIN_LIMIT;
        end else begin
            limit = BASE_LIMIT - product[COUNT_WIDTH-1:0];
        end
    end

    always_comb begin
        count_d = count_q;
`ifdef SC_SPEEDTIMER_LEVELUP_EN
        shifts_d   = shifts_q;
        level_d    = level_q;
        level_up_d = 1'b0;
`endif
        if (!SC_SPEEDTIMER_clear_InLow) begin
            count_d = '0;
`ifdef SC_SPEEDTIMER_LEVELUP_EN
            shifts_d = '0;
            level_d  = '0;
`endif
        end else if (!SC_SPEEDTIMER_load_InLow) begin
            count_d = '0;
`ifdef SC_SPEEDTIMER_LEVELUP_EN
            if (shifts_q == SHIFT_W'(SHIFTS_PER_LEVEL - 1)) begin
                shifts_d = '0;
                if (!(&level_q)) begin
                    level_d    = level_q + 1'b1;
                    level_up_d = 1'b1;
                end
            end else begin
                shifts_d = shifts_q + 1'b1;
            end
`endif
        end else if (!SC_SPEEDTIMER_upcount_InLow && (count_q < limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge SC_SPEEDTIMER_CLOCK_50 or negedge SC_SPEEDTIMER_RESET_InLow) begin
        if (!SC_SPEEDTIMER_RESET_InLow) begin
            count_q <= '0;
`ifdef SC_SPEEDTIMER_LEVELUP_EN
            shifts_q   <= '0;
            level_q    <= '0;
            level_up_q <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
`ifdef SC_SPEEDTIMER_LEVELUP_EN
            shifts_q   <= shifts_d;
            level_q    <= level_d;
            level_up_q <= level_up_d;
`endif
        end
    end

    assign SC_SPEEDTIMER_T0_OutLow       = (count_q >= limit) ? 1'b0 : 1'b1;
    assign SC_SPEEDTIMER_level_Out       = level_w;
    assign SC_SPEEDTIMER_levelUp_OutHigh = level_up_w;

endmodule

// File: tb/tb_sc_speedtimer.sv
// Directed bench for sc_speedtimer (BASE 10, STEP 2, MIN 4, 2-bit level, 2 shifts per level).
// Level-progression scenarios run when SC_SPEEDTIMER_LEVELUP_EN is defined; otherwise the fixed-period checks run.
module tb_sc_speedtimer;

    logic       clk;
    logic       rst_n;
    logic       clear_n;
    logic       load_n;
    logic       up_n;
    logic       t0_n;
    logic [1:0] level;
    logic       level_up;

    int checks;
    int errors;

    sc_speedtimer #(
        .COUNT_WIDTH     (8),
        .BASE_LIMIT      (8'd10),
        .LEVEL_STEP      (8'd2),
        .MIN_LIMIT       (8'd4),
        .LEVEL_WIDTH     (2),
        .SHIFTS_PER_LEVEL(2)
    ) dut (
        .SC_SPEEDTIMER_CLOCK_50       (clk),
        .SC_SPEEDTIMER_RESET_InLow    (rst_n),
        .SC_SPEEDTIMER_clear_InLow    (clear_n),
        .SC_SPEEDTIMER_load_InLow     (load_n),
        .SC_SPEEDTIMER_upcount_InLow  (up_n),
        .SC_SPEEDTIMER_T0_OutLow      (t0_n),
        .SC_SPEEDTIMER_level_Out      (level),
        .SC_SPEEDTIMER_levelUp_OutHigh(level_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive active-low strobes for n edges, sampling settles 1ns after the last edge.
    task automatic strobe(input logic c, input logic l, input logic u, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_n = ~c;
            load_n  = ~l;
            up_n    = ~u;
            @(posedge clk);
            #1;
            clear_n = 1'b1;
            load_n  = 1'b1;
            up_n    = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear_n = 1'b1; load_n = 1'b1; up_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL reset_t0 got %b want 1", t0_n); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (level_up !== 1'b0) begin errors++; $display("FAIL reset_levelup got %b want 0", level_up); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_period;
        strobe(0, 0, 1, 9);
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL period_9 got %b want 1", t0_n); end
        strobe(0, 0, 1, 1);
        checks++; if (t0_n !== 1'b0) begin errors++; $display("FAIL period_10 got %b want 0", t0_n); end
        for (int i = 0; i < 5; i++) begin
            strobe(0, 0, 1, 1);
            checks++; if (t0_n !== 1'b0) begin errors++; $display("FAIL period_sat%0d got %b want 0", i, t0_n); end
        end
    endtask

    task automatic test_priority;
        strobe(1, 1, 1, 1);
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL prio_clr_t0 got %b want 1", t0_n); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL prio_clr_level got %0d want 0", level); end
        checks++; if (level_up !== 1'b0) begin errors++; $display("FAIL prio_clr_levelup got %b want 0", level_up); end
        strobe(0, 0, 1, 9);
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL prio_clr_cnt got %b want 1", t0_n); end
        // Load wins over upcount: counter returns to zero, so 9 more strobes stay short of the limit.
        strobe(0, 1, 1, 1);
        strobe(0, 0, 1, 9);
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL prio_ld_cnt9 got %b want 1", t0_n); end
        strobe(0, 0, 1, 1);
        checks++; if (t0_n !== 1'b0) begin errors++; $display("FAIL prio_ld_cnt10 got %b want 0", t0_n); end
        strobe(1, 0, 0, 1);
    endtask

    task automatic test_async_reset(input logic [1:0] exp_level_before);
        strobe(0, 0, 1, 3);
        checks++; if (level !== exp_level_before) begin errors++; $display("FAIL arst_pre_level got %0d want %0d", level, exp_level_before); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL arst_level got %0d want 0", level); end
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL arst_t0 got %b want 1", t0_n); end
        checks++; if (level_up !== 1'b0) begin errors++; $display("FAIL arst_levelup got %b want 0", level_up); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef SC_SPEEDTIMER_LEVELUP_EN
    task automatic test_levelup;
        strobe(1, 0, 0, 1);
        strobe(0, 0, 1, 10);
        strobe(0, 1, 0, 1);
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL lu_load1_t0 got %b want 1", t0_n); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL lu_load1_level got %0d want 0", level); end
        strobe(0, 1, 0, 1);
        checks++; if (level !== 2'd1) begin errors++; $display("FAIL lu_load2_level got %0d want 1", level); end
        checks++; if (level_up !== 1'b1) begin errors++; $display("FAIL lu_pulse got %b want 1", level_up); end
        strobe(0, 0, 1, 1);
        checks++; if (level_up !== 1'b0) begin errors++; $display("FAIL lu_pulse_end got %b want 0", level_up); end
        strobe(0, 0, 1, 6);
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL lu_lim8_7 got %b want 1", t0_n); end
        strobe(0, 0, 1, 1);
        checks++; if (t0_n !== 1'b0) begin errors++; $display("FAIL lu_lim8_8 got %b want 0", t0_n); end
    endtask

    task automatic test_saturation;
        strobe(1, 0, 0, 1);
        strobe(0, 1, 0, 6);
        checks++; if (level !== 2'd3) begin errors++; $display("FAIL sat_level got %0d want 3", level); end
        checks++; if (level_up !== 1'b1) begin errors++; $display("FAIL sat_pulse6 got %b want 1", level_up); end
        strobe(0, 0, 1, 3);
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL sat_lim4_3 got %b want 1", t0_n); end
        strobe(0, 0, 1, 1);
        checks++; if (t0_n !== 1'b0) begin errors++; $display("FAIL sat_lim4_4 got %b want 0", t0_n); end
        for (int i = 0; i < 2; i++) begin
            strobe(0, 1, 0, 1);
            checks++; if (level !== 2'd3) begin errors++; $display("FAIL sat_hold%0d got %0d want 3", i, level); end
            checks++; if (level_up !== 1'b0) begin errors++; $display("FAIL sat_nopulse%0d got %b want 0", i, level_up); end
        end
        // Priority under a nonzero level: clear wins and cancels the pending pulse.
        strobe(1, 1, 1, 1);
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL sat_clr_level got %0d want 0", level); end
    endtask
`else
    task automatic test_no_levelup;
        strobe(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            strobe(0, 1, 0, 1);
            checks++; if (level !== 2'd0) begin errors++; $display("FAIL nolu_level%0d got %0d want 0", i, level); end
            checks++; if (level_up !== 1'b0) begin errors++; $display("FAIL nolu_pulse%0d got %b want 0", i, level_up); end
        end
        strobe(0, 0, 1, 9);
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL nolu_9 got %b want 1", t0_n); end
        strobe(0, 0, 1, 1);
        checks++; if (t0_n !== 1'b0) begin errors++; $display("FAIL nolu_10 got %b want 0", t0_n); end
        strobe(0, 1, 0, 1);
        checks++; if (t0_n !== 1'b1) begin errors++; $display("FAIL nolu_load_t0 got %b want 1", t0_n); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_period();
        test_priority();
`ifdef SC_SPEEDTIMER_LEVELUP_EN
        test_levelup();
        test_saturation();
        strobe(1, 0, 0, 1);
        strobe(0, 1, 0, 4);
        test_async_reset(2'd2);
`else
        test_no_levelup();
        test_async_reset(2'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_speedtimer.md
# sc_speedtimer

Shift-period timer directly downstream of the main game state machine and feeding its terminal-count input. It counts the state machine's active-low upcount strobes and drives `T0_OutLow` low once the current scroll period has elapsed. The state machine answers with a load (shift) strobe, which restarts the period and advances a difficulty level that shortens later periods.

## Interface
- `COUNT_WIDTH`, default 24: width of the period counter and of all limit parameters.
- `BASE_LIMIT`, default 24'd200000: period length at level 0, in upcount strobes.
- `LEVEL_STEP`, default 24'd20000: amount the period shrinks per level.
- `MIN_LIMIT`, default 24'd40000: floor on the period length; must be ≥1 and ≤ `BASE_LIMIT`.
- `LEVEL_WIDTH`, default 3: width of the level register.
- `SHIFTS_PER_LEVEL`, default 16: number of load strobes per level increment; must be ≥1.
- `SC_SPEEDTIMER_CLOCK_50` in 1: system clock; all state changes on its rising edge.
- `SC_SPEEDTIMER_RESET_InLow` in 1: reset, asynchronous, active-low.
- `SC_SPEEDTIMER_clear_InLow` in 1: game init; zeroes the counter, the shift count and the level.
- `SC_SPEEDTIMER_load_InLow` in 1: shift strobe; restarts the period and counts one shift.
- `SC_SPEEDTIMER_upcount_InLow` in 1: count strobe; adds one to the period counter.
- `SC_SPEEDTIMER_T0_OutLow` out 1: period elapsed, active low.
- `SC_SPEEDTIMER_level_Out` out `LEVEL_WIDTH`: current difficulty level.
- `SC_SPEEDTIMER_levelUp_OutHigh` out 1: one-cycle pulse on each level increment.

## Operation
- Registers:
  - `count`: `COUNT_WIDTH` bits.
  - `shifts`: `$clog2(SHIFTS_PER_LEVEL)` bits, minimum 1.
  - `level`: `LEVEL_WIDTH` bits.
  - `levelUp`: 1 bit.
- Effective limit, combinational from `level`:
  - `limit = BASE_LIMIT - level*LEVEL_STEP`, computed in `COUNT_WIDTH+LEVEL_WIDTH` bits.
  - If the product ≥ `BASE_LIMIT - MIN_LIMIT`, `limit = MIN_LIMIT`. No underflow is possible.
- `T0_OutLow = (count >= limit) ? 0 : 1`. It is decoded from registers only; there is no combinational path from the inputs.
- Per-edge update priority is clear > load > upcount. Lower-priority strobes in the same cycle are ignored.
- Clear, when `clear_InLow`=0:
  - `count`, `shifts` and `level` ← 0.
  - `levelUp` ← 0.
- Load, when `load_InLow`=0 and clear is inactive:
  - `count` ← 0.
  - If `shifts == SHIFTS_PER_LEVEL-1`: `shifts` ← 0.
    - If `level` < max: `level` ← `level`+1 and `levelUp` ← 1.
    - If `level` is at max (all ones), it saturates and `levelUp` stays 0.
  - Otherwise `shifts` ← `shifts`+1.
- Upcount, when `upcount_InLow`=0 with no clear and no load:
  - If `count < limit`, `count` ← `count`+1.
  - Otherwise `count` holds: it saturates at the limit and never wraps.
- `levelUp` ← 0 on every edge not listed above, so it is high for exactly one cycle.
- Strobes are level-sampled on every edge. A strobe held low for N cycles acts N times.

## Timing
- Reset values (asynchronous):
  - `count`, `shifts`, `level` = 0.
  - `T0_OutLow` = 1.
  - `level_Out` = 0.
  - `levelUp_OutHigh` = 0.
- Reset asserted mid-period forces all outputs to these values immediately, without waiting for a clock edge. The first update after deassertion happens on the next rising edge.
- Upcount to T0:
  - The edge that samples the `limit`-th upcount strobe sets `count = limit`.
  - `T0_OutLow` falls after that same edge (0-cycle latency from the register).
- Load to T0:
  - `T0_OutLow` returns high after the edge that samples load.
  - `level_Out` and `levelUp_OutHigh` update on that same edge.
- A level change takes effect in the same cycle. Because load also zeroes `count`, `T0` is high immediately after any level increment.
- Loop timing: the state machine issues a strobe at most every 2 cycles. The block still accepts back-to-back strobes on every cycle.

## Configuration
- `SC_SPEEDTIMER_LEVELUP_EN` defined: level progression as described above.
- `SC_SPEEDTIMER_LEVELUP_EN` undefined:
  - `level` and `shifts` are not built.
  - `level_Out` is tied to 0 and `levelUp_OutHigh` to 0.
  - `limit` is `BASE_LIMIT` constant.
  - Load only zeroes `count`.

## Test plan
Bench parameters: `COUNT_WIDTH`=8, `BASE_LIMIT`=10, `LEVEL_STEP`=2, `MIN_LIMIT`=4, `LEVEL_WIDTH`=2, `SHIFTS_PER_LEVEL`=2; macro defined.
- **Reset then period:** release reset, then give 9 upcount strobes → `T0`=1. On the 10th strobe → `T0`=0 after that edge. 5 further strobes → `count` stays 10, `T0`=0.
- **Load and level up:** with `T0`=0, load → `T0`=1 and `count`=0. Second load → `level`=1, `levelUp` pulses 1 cycle, and `T0` falls after 8 strobes.
- **Level saturation:** 6 loads → `level`=3 and the limit is 4. 2 more loads → `level` stays 3 with no `levelUp` pulse. Limit is 4 (`MIN_LIMIT`) at level 3.
- **Priority:** clear+load+upcount in the same cycle → `count`=0, `level`=0, no pulse. Load+upcount → `count`=0.
- **Async reset:** pull reset low mid-period at `level`=2 between edges → `level_Out`=0 and `T0`=1 before the next edge.
- **Macro undefined:** 4 loads → `level_Out`=0 and `levelUp`=0 throughout; the period stays at 10 strobes.
